can_bit_destuffer: RTL and testbench

CAN_BIT_DESTUFFER -- requirements
Module: can_bit_destuffer

---
 rtl/can_bit_destuffer.sv | 164 ++++++++++++++++
 tb/tb_can_bit_destuffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/can_bit_destuffer.sv
// CAN bit sampler and destuffer: hard-syncs on SOF, samples at SAMPLE_POINT, drops stuff bits; strobes registered one cycle after the sample.
// No backpressure (one sample per bit time). Defining CAN_DESTUFF_ERR_COUNT_EN adds a saturating o_Err_Count.
module can_bit_destuffer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int SAMPLE_POINT = 7,
    parameter int STUFF_LIMIT  = 5,
    parameter int IDLE_BITS    = 11
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Ds_Serial,
    input  logic       i_Enable,
    input  logic       i_Stuff_En,
    output logic       o_Bit_Valid,
    output logic       o_Bit,
    output logic       o_Ignora_Bit,
    output logic       o_Eror_Stuffing,
`ifdef CAN_DESTUFF_ERR_COUNT_EN
    output logic [7:0] o_Err_Count,
`endif
    output logic       o_Busy
);

    localparam int IW = $clog2(IDLE_BITS + 1);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_ds_meta, r_ds_s, r_ds_d;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [3:0]      r_run_len, w_run_len_nxt;
    logic            r_run_val, w_run_val_nxt;
    logic [IW-1:0]   r_idle_cnt, w_idle_cnt_nxt;
    logic            r_bit_vld, w_bit_vld_nxt;
    logic            r_bit, w_bit_nxt;
    logic            r_ign, w_ign_nxt;
    logic            r_err, w_err_nxt;
    logic            w_fall, w_sample;

    assign w_fall   = r_ds_d & ~r_ds_s;
    assign w_sample = (r_state == S_RUN) && (r_cnt == 8'(SAMPLE_POINT));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_ds_meta <= 1'b1;
            r_ds_s    <= 1'b1;
            r_ds_d    <= 1'b1;
        end else begin
            r_ds_meta <= i_Ds_Serial;
            r_ds_s    <= r_ds_meta;
            r_ds_d    <= r_ds_s;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_run_len_nxt  = r_run_len;
        w_run_val_nxt  = r_run_val;
        w_idle_cnt_nxt = r_idle_cnt;
        w_bit_vld_nxt  = 1'b0;
        w_bit_nxt      = r_bit;
        w_ign_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The edge cycle itself is Clock_Count 0, so the next cycle is 1.
                if (i_Enable && w_fall) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = (r_cnt == 8'(CLKS_PER_BIT - 1)) ? 8'd0 : r_cnt + 8'd1;
                if (!i_Enable) begin
                    w_state_nxt = S_IDLE;
                end else if (w_sample) begin
                    if (r_ds_s) begin
                        w_idle_cnt_nxt = r_idle_cnt + IW'(1);
                        if (r_idle_cnt == IW'(IDLE_BITS - 1))
                            w_state_nxt = S_IDLE;
                    end else begin
                        w_idle_cnt_nxt = '0;
                    end
                    if (!i_Stuff_En) begin
                        w_bit_vld_nxt = 1'b1;
                        w_bit_nxt     = r_ds_s;
                        w_run_len_nxt = 4'd0;
                    end else if (r_run_len == 4'(STUFF_LIMIT)) begin
                        if (r_ds_s != r_run_val) begin
                            w_ign_nxt     = 1'b1;
                            w_run_len_nxt = 4'd1;
                            w_run_val_nxt = r_ds_s;
                        end else begin
                            w_err_nxt     = 1'b1;
                            w_run_len_nxt = 4'd0;
                            w_state_nxt   = S_IDLE;
                        end
                    end else begin
                        w_bit_vld_nxt = 1'b1;
                        w_bit_nxt     = r_ds_s;
                        if (r_ds_s == r_run_val) begin
                            w_run_len_nxt = r_run_len + 4'd1;
                        end else begin
                            w_run_len_nxt = 4'd1;
                            w_run_val_nxt = r_ds_s;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Leaving or staying in IDLE always parks the counters at zero.
        if (w_state_nxt == S_IDLE) begin
            w_cnt_nxt      = 8'd0;
            w_run_len_nxt  = 4'd0;
            w_idle_cnt_nxt = '0;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_run_len  <= 4'd0;
            r_run_val  <= 1'b1;
            r_idle_cnt <= '0;
            r_bit_vld  <= 1'b0;
            r_bit      <= 1'b1;
            r_ign      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_run_len  <= w_run_len_nxt;
            r_run_val  <= w_run_val_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_bit_vld  <= w_bit_vld_nxt;
            r_bit      <= w_bit_nxt;
            r_ign      <= w_ign_nxt;
            r_err      <= w_err_nxt;
        end
    end

`ifdef CAN_DESTUFF_ERR_COUNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset)
            r_err_cnt <= 8'd0;
        else if (r_err && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign o_Err_Count = r_err_cnt;
`endif

    assign o_Bit_Valid     = r_bit_vld;
    assign o_Bit           = r_bit;
    assign o_Ignora_Bit    = r_ign;
    assign o_Eror_Stuffing = r_err;
    assign o_Busy          = (r_state == S_RUN);

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Random and directed CAN frames; a bit-level reference model fills a queue that a strobe monitor drains.
`timescale 1ns/1ps
module tb_can_bit_destuffer;

    localparam int CPB = 10;
    localparam int SL  = 5;
    localparam int IB  = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ds  = 1'b1;
    logic en  = 1'b0;
    logic se  = 1'b0;
    logic o_vld, o_bit, o_ign, o_err, o_busy;
`ifdef CAN_DESTUFF_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    can_bit_destuffer #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(7), .STUFF_LIMIT(SL), .IDLE_BITS(IB)) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_Ds_Serial(ds),
        .i_Enable(en),
        .i_Stuff_En(se),
        .o_Bit_Valid(o_vld),
        .o_Bit(o_bit),
        .o_Ignora_Bit(o_ign),
        .o_Eror_Stuffing(o_err),
`ifdef CAN_DESTUFF_ERR_COUNT_EN
        .o_Err_Count(err_count),
`endif
        .o_Busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] kind;   // {valid, ignore, error}
        logic       b;
        logic       busy;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  first_strobe_cyc = -1;
    int  exp_err_total = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst && (o_vld || o_ign || o_err)) begin
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {o_vld, o_ign, o_err}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_kind", {o_vld, o_ign, o_err}, e.kind);
                if (e.kind == 3'b100) chk("bit_value", o_bit, e.b);
                chk("busy_at_strobe", o_busy, e.busy);
            end
        end
    end

    // Bit-level model: one entry per line bit, sampled once per bit time while a frame is active.
    task automatic model(input bit ln[$], input bit sv[$], output bit busy_end);
        bit running = 1'b0;
        bit prev = 1'b1;
        bit rv = 1'b1;
        int rl = 0;
        int ic = 0;
        ev_t e;
        foreach (ln[i]) begin
            if (!running && prev && !ln[i]) begin
                running = 1'b1;
                rl = 0;
                ic = 0;
            end
            if (running) begin
                bit s;
                bit stop;
                s = ln[i];
                ic = s ? ic + 1 : 0;
                stop = (ic == IB);
                e.b = s;
                if (!sv[i]) begin
                    e.kind = 3'b100;
                    rl = 0;
                end else if (rl == SL) begin
                    if (s != rv) begin
                        e.kind = 3'b010;
                        rl = 1;
                        rv = s;
                    end else begin
                        e.kind = 3'b001;
                        rl = 0;
                        stop = 1'b1;
                        exp_err_total++;
                    end
                end else begin
                    e.kind = 3'b100;
                    if (s == rv) rl++;
                    else begin
                        rl = 1;
                        rv = s;
                    end
                end
                e.busy = !stop;
                exp_q.push_back(e);
                if (stop) running = 1'b0;
            end
            prev = ln[i];
        end
        busy_end = running;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bits(input bit ln[$], input bit sv[$]);
        foreach (ln[i]) begin
            ds = ln[i];
            se = sv[i];
            cycles(CPB);
        end
    endtask

    task automatic frame(input int n, input logic [31:0] bits, input logic [31:0] sev, input int trail);
        bit ln[$];
        bit sv[$];
        bit be;
        for (int i = 0; i < n; i++) begin
            ln.push_back(bits[i]);
            sv.push_back(sev[i]);
        end
        for (int i = 0; i < trail; i++) begin
            ln.push_back(1'b1);
            sv.push_back(1'b0);
        end
        model(ln, sv, be);
        drive_bits(ln, sv);
        cycles(4);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        chk("busy_end", o_busy, be);
    endtask

    task automatic reset_test();
        bit ln[$];
        bit sv[$];
        bit be;
        ln = {1'b0, 1'b1, 1'b0};
        sv = {1'b1, 1'b1, 1'b1};
        model(ln, sv, be);
        drive_bits(ln, sv);
        ds = 1'b1;
        cycles(3);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_vld", o_vld, 0);
        chk("rst_async_bit", o_bit, 1);
        chk("rst_async_ign", o_ign, 0);
        chk("rst_async_err", o_err, 0);
        chk("rst_async_busy", o_busy, 0);
        cycles(2);
        rst = 1'b0;
        cycles(5);
        chk("rst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        // Six dominant bits: SOF must restart the run at 1, so the sixth is the error.
        frame(6, 32'h0, 32'hFFFF_FFFF, 13);
    endtask

    task automatic enable_test();
        bit ln[$];
        bit sv[$];
        bit be;
        ln = {1'b0, 1'b1};
        sv = {1'b1, 1'b1};
        model(ln, sv, be);
        drive_bits(ln, sv);
        ds = 1'b0;
        cycles(5);
        en = 1'b0;
        cycles(2);
        chk("en_low_busy", o_busy, 0);
        cycles(10);
        ds = 1'b1;
        cycles(5);
        en = 1'b1;
        cycles(5);
        chk("en_queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic random_frame();
        logic [31:0] bits;
        logic [31:0] sev;
        int n;
        int run;
        logic cur;
        n = $urandom_range(8, 30);
        bits = '0;
        sev = '0;
        cur = 1'b0;
        run = $urandom_range(1, 7);
        for (int i = 0; i < n; i++) begin
            if (run == 0) begin
                cur = ~cur;
                run = $urandom_range(1, 7);
            end
            bits[i] = cur;
            run--;
            sev[i] = ($urandom_range(0, 7) != 0);
        end
        frame(n, bits, sev, 13);
    endtask

    initial begin
        int t0;
        cycles(3);
        chk("reset_vld", o_vld, 0);
        chk("reset_bit", o_bit, 1);
        chk("reset_ign", o_ign, 0);
        chk("reset_err", o_err, 0);
        chk("reset_busy", o_busy, 0);
        rst = 1'b0;
        en = 1'b1;
        cycles(5);

        first_strobe_cyc = -1;
        t0 = cyc;
        frame(4, 32'hA, 32'hFFFF_FFFF, 13);
        chk("sof_latency", first_strobe_cyc - t0, 10);

        frame(7, 32'h60, 32'hFFFF_FFFF, 13);
        frame(6, 32'h0, 32'hFFFF_FFFF, 13);
        frame(7, 32'h7E, 32'h0, 13);
        reset_test();
        enable_test();

        for (int k = 0; k < 40; k++) random_frame();

`ifdef CAN_DESTUFF_ERR_COUNT_EN
        chk("err_count_running", err_count, (exp_err_total > 255) ? 255 : exp_err_total);
        for (int k = 0; k < 257; k++) frame(6, 32'h0, 32'hFFFF_FFFF, 1);
        chk("err_count_saturated", err_count, 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
